skew_feeder: RTL
================

Name: skew_feeder

Overview:
- Multi-lane successor to the single-lane load-and-shift register.
- Accepts one packed block per lane: BLOCK_SIZE elements of DATA_WIDTH bits, NUM_LANES lanes, loaded in a single cycle.
- Serialises each lane one element per advance, with lane i delayed by i cycles. This produces the diagonal wavefront the systolic PE array expects on its row/column edge.
- Adds a load/ready handshake, a stall input, per-lane valid, zero-fill bubbles, a selectable element order and a completion pulse.

Parameters:
- DATA_WIDTH, 8, bits per matrix element.
- BLOCK_SIZE, 3, elements per lane (matrix dimension).
- NUM_LANES, 3, number of parallel lanes (array edge width).
- MSB_FIRST, 1, 1 = element at the highest bit slice of a lane is emitted first; 0 = lowest slice first.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  request to capture data_in.
- data_in  in  NUM_LANES*BLOCK_SIZE*DATA_WIDTH  lane i occupies bits [(i+1)*BLOCK_SIZE*DATA_WIDTH-1 : i*BLOCK_SIZE*DATA_WIDTH].
- en  in  1  advance enable; 0 = stall, all state and outputs hold.
- ready  out  1  high in IDLE; a load is accepted only when ready is high.
- data_out  out  NUM_LANES*DATA_WIDTH  lane i element at slice i.
- valid_out  out  NUM_LANES  per-lane qualifier for data_out.
- done  out  1  one-cycle pulse after the last element of the last lane.

Behaviour:
- Reset values: state=IDLE, cnt=0, storage=0, ready=1, data_out=0, valid_out=0, done=0.
- Reset has priority over load and en, and aborts a drain in progress. The cycle after reset deasserts, outputs are at their reset values.
- States: IDLE and SHIFT. Counter cnt is $clog2(BLOCK_SIZE+NUM_LANES) bits wide. LAST = BLOCK_SIZE+NUM_LANES-2.
- IDLE: on an edge with load=1, capture data_in, set cnt=0 and go to SHIFT. en is ignored in IDLE. load=0 keeps the block in IDLE.
- SHIFT: ready=0 and load is ignored.
  - On an edge with en=1: if cnt==LAST, go to IDLE; otherwise cnt increments.
  - On an edge with en=0: nothing changes.
- Lane i in SHIFT:
  - valid_out[i] = (cnt >= i) && (cnt < i+BLOCK_SIZE).
  - When valid, data_out slice i = element k = cnt-i, counted in the order set by MSB_FIRST.
  - When not valid, the slice is 0 (bubble). Zero is MAC-neutral for the array.
- Outputs are derived from registered state only; there is no data_in-to-data_out combinational path.
- Latency: lane 0 element 0 appears in the first cycle after the accepting edge. Lane i element 0 appears i cycles later.
- Drain: takes BLOCK_SIZE+NUM_LANES-1 advancing cycles.
- done: registered; high for exactly the first cycle after the SHIFT→IDLE transition. ready is also 1 in that cycle.
- Back-to-back loads: a load in the cycle done=1 is accepted, giving a one-cycle gap between blocks. No overlap of blocks.
- IDLE outputs: data_out=0 and valid_out=0.
- Degenerate sizes: BLOCK_SIZE=1 and NUM_LANES=1 must work. With NUM_LANES=1 the block behaves as the plain shift register plus handshake.

Decomposition:
- Shared package (systolic_pkg):
  - DATA_WIDTH, BLOCK_SIZE defaults.
  - Element typedef (logic [DATA_WIDTH-1:0]).
  - State enum {IDLE, SHIFT}.
- Sub-module skew_lane: one lane's storage plus element select. Inputs are cnt and its lane index; outputs are the element and valid. Instantiated NUM_LANES times in a generate loop. Control FSM and counter stay in the top.

Test Plan:
- Basic load (defaults), load with lane2=A1B2C3, lane1=D4E5F6, lane0=112233, en=1:
  - Lane0 emits 11,22,33 at cycles 1-3.
  - Lane1 emits D4,E5,F6 at cycles 2-4.
  - Lane2 emits A1,B2,C3 at cycles 3-5.
  - Bubbles are 00 with valid=0.
  - done=1 at cycle 6; ready=0 during cycles 1-5.
- MSB_FIRST=0, same data: lane2 emits C3,B2,A1; lane0 emits 33,22,11; timing identical.
- Stall: deassert en for 2 cycles after lane1 has emitted D4. Outputs and valid_out hold for those 2 cycles; the sequence resumes with E5, and done is delayed by exactly 2 cycles.
- Load during SHIFT: pulse load with new data at cycle 2. It is ignored, and the output sequence is unchanged.
- Back-to-back: assert load with a second block in the done cycle. The second block's lane0 element 0 appears the next cycle; no sample is lost or duplicated.
- Reset mid-drain: assert reset at cycle 3. The next cycle shows data_out=0, valid_out=0, ready=1, done=0, and a fresh load then proceeds normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array edge feeders: default element
// geometry, the element type and the feeder control states.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BLOCK_SIZE = 3;

  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// One feeder lane: holds a captured block and picks the element that belongs
// on the wavefront for a given counter value. The lane index sets how many
// cycles this lane lags lane 0. Select outputs are combinational on the
// next-cycle control values so the top can register them.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int LANE_IDX   = 0,
  parameter int MSB_FIRST  = 1,
  parameter int CNT_W      = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             capture,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] lane_data,
  input  logic [CNT_W-1:0]                 cnt,
  input  logic                             active,
  output logic [DATA_WIDTH-1:0]            elem,
  output logic                             valid
);

  logic [BLOCK_SIZE*DATA_WIDTH-1:0] store_r;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] store_s;
  int                               cnt_i;
  int                               k_i;
  int                               slice_i;

  // Storage seen next cycle: a fresh block when capturing, otherwise held.
  always_comb begin
    store_s = store_r;
    if (capture) begin
      store_s = lane_data;
    end else begin
      store_s = store_r;
    end
  end

  // Block storage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_r <= '0;
    end else begin
      store_r <= store_s;
    end
  end

  // Element select: the lane is live for BLOCK_SIZE counts starting at its
  // index; outside that window it emits a zero bubble.
  always_comb begin
    elem    = '0;
    valid   = 1'b0;
    cnt_i   = int'(cnt);
    k_i     = 0;
    slice_i = 0;
    if (active && (cnt_i >= LANE_IDX) && (cnt_i < LANE_IDX + BLOCK_SIZE)) begin
      valid   = 1'b1;
      k_i     = cnt_i - LANE_IDX;
      slice_i = (MSB_FIRST != 0) ? (BLOCK_SIZE - 1 - k_i) : k_i;
      elem    = DATA_WIDTH'(store_s >> (slice_i * DATA_WIDTH));
    end else begin
      valid = 1'b0;
      elem  = '0;
    end
  end

endmodule

// File: rtl/skew_feeder.sv
// Multi-lane skewed feeder: loads one block per lane in a single cycle, then
// streams each lane one element per advance with lane i lagging by i cycles,
// forming the diagonal wavefront a systolic PE array consumes on its edge.
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_LANES  = 3,
  parameter int MSB_FIRST  = 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       load,
  input  logic [NUM_LANES*BLOCK_SIZE*DATA_WIDTH-1:0] data_in,
  input  logic                                       en,
  output logic                                       ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0]            data_out,
  output logic [NUM_LANES-1:0]                       valid_out,
  output logic                                       done
);

  localparam int LANE_W = BLOCK_SIZE * DATA_WIDTH;
  localparam int CNT_W  = $clog2(BLOCK_SIZE + NUM_LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_SIZE + NUM_LANES - 2);

  feeder_state_t                   state_r;
  feeder_state_t                   state_s;
  logic [CNT_W-1:0]                cnt_r;
  logic [CNT_W-1:0]                cnt_s;
  logic                            capture_s;
  logic                            done_s;
  logic                            active_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_elem_s;
  logic [NUM_LANES-1:0]            lane_valid_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] data_out_r;
  logic [NUM_LANES-1:0]            valid_out_r;
  logic                            ready_r;
  logic                            done_r;

  // Next-state logic: accept a block in IDLE, advance the wavefront on en
  // in SHIFT and return to IDLE after the last lane's last element.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (load) begin
          capture_s = 1'b1;
          cnt_s     = '0;
          state_s   = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt_r == LAST) begin
            state_s = IDLE;
            cnt_s   = '0;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  assign active_s = (state_s == SHIFT);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    skew_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .BLOCK_SIZE(BLOCK_SIZE),
      .LANE_IDX  (i),
      .MSB_FIRST (MSB_FIRST),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .capture  (capture_s),
      .lane_data(data_in[i*LANE_W +: LANE_W]),
      .cnt      (cnt_s),
      .active   (active_s),
      .elem     (lane_elem_s[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid    (lane_valid_s[i])
    );
  end

  // Control state plus registered outputs, all loaded from next-cycle values
  // so every port comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      data_out_r  <= '0;
      valid_out_r <= '0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      data_out_r  <= lane_elem_s;
      valid_out_r <= lane_valid_s;
      ready_r     <= (state_s == IDLE);
      done_r      <= done_s;
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign ready     = ready_r;
  assign done      = done_r;

endmodule
